// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU control decoding and the multiply sequencer.
// The states are shared by mul_seq_ctrl and anything that observes its progress.
package mul_seq_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul(input logic [2:0] alu_ctrl);
    return alu_ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// EX-stage request/response bundle for the multiply sequencer.
// The pipeline drives the master side; mul_seq_ctrl is the slave.
interface mul_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] result_o;
  logic             done_o;
  logic             stall_o;
  logic             busy_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  result_o, done_o, stall_o, busy_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output result_o, done_o, stall_o, busy_o
  );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand, multiplier and accumulator registers.
// MUL_EARLY_TERM_EN: also signal termination once the shifted multiplier is zero.
module mul_shift_add_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_next_o,
  output logic             term_o
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

`ifdef MUL_EARLY_TERM_EN
  assign term_o = last_i || (mplier_d == '0);
`else
  assign term_o = last_i;
`endif

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle multiply sequencer: stalls the pipeline while a MUL iterates, then pulses done.
// Optional MUL_EARLY_TERM_EN (see mul_shift_add_dp) makes latency multiplier-dependent.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  mul_seq_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  mul_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             issue, load, step, last_step;
  logic [WIDTH-1:0] acc_next;
  logic             term;

  assign last_step = (count_q == CW'(WIDTH - 1));

  mul_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .last_i     (last_step),
    .mcand_i    (bus.data1_i),
    .mplier_i   (bus.data2_i),
    .acc_next_o (acc_next),
    .term_o     (term)
  );

  // DONE never looks at the request: the instruction is still held there and must not re-issue.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    issue    = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid_i && is_mul(bus.ALUCtrl_i)) begin
          issue   = 1'b1;
          load    = 1'b1;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step    = 1'b1;
        count_d = count_q + 1'b1;
        if (term) begin
          result_d = acc_next;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign bus.stall_o  = issue || (state_q == ST_RUN);
  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: driver queues expected products and done cycles,
// a monitor pops them on every done_o pulse.
module tb_mul_seq_ctrl;
  import mul_seq_ctrl_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t sb_q[$];
  logic [W-1:0] exp_hold;

  mul_seq_ctrl_if #(.WIDTH(W)) bus ();

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain double-width product and the multiplier-driven iteration count.
  function automatic logic [W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return full[W-1:0];
  endfunction

  function automatic int unsigned model_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int unsigned l = 1;
    for (int unsigned i = 0; i < W; i++) if (b[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned lat;
    lat = model_lat(b);
    @(posedge clk); #1;
    bus.valid_i = 1'b1; bus.ALUCtrl_i = ALU_MUL; bus.data1_i = a; bus.data2_i = b;
    sb_q.push_back('{res: model_prod(a, b), cyc: cyc + lat + 1});
    @(negedge clk);
    chk("issue_stall", W'(bus.stall_o), W'(1));
    chk("issue_busy", W'(bus.busy_o), W'(0));
    for (int unsigned i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("run_stall", W'(bus.stall_o), W'(1));
      chk("run_busy", W'(bus.busy_o), W'(1));
    end
    @(negedge clk);
    chk("done_stall", W'(bus.stall_o), W'(0));
    chk("done_busy", W'(bus.busy_o), W'(1));
    exp_hold = model_prod(a, b);
  endtask

  task automatic bypass_cycle(input logic v, input logic [2:0] ctrl);
    @(posedge clk); #1;
    bus.valid_i = v; bus.ALUCtrl_i = ctrl;
    bus.data1_i = $urandom; bus.data2_i = $urandom;
    @(negedge clk);
    chk("bypass_stall", W'(bus.stall_o), W'(0));
    chk("bypass_busy", W'(bus.busy_o), W'(0));
    chk("bypass_done", W'(bus.done_o), W'(0));
    chk("bypass_result", bus.result_o, exp_hold);
  endtask

  task automatic rand_bypass(input int unsigned n);
    logic [2:0] c;
    for (int unsigned i = 0; i < n; i++) begin
      c = 3'($urandom_range(0, 7));
      if (c == ALU_MUL) bypass_cycle(1'b0, c);
      else bypass_cycle(1'($urandom_range(0, 1)), c);
    end
  endtask

  task automatic reset_mid_op();
    @(posedge clk); #1;
    bus.valid_i = 1'b1; bus.ALUCtrl_i = ALU_MUL; bus.data1_i = 100; bus.data2_i = 100;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.valid_i = 1'b0;
    exp_hold = '0;
    @(negedge clk);
    chk("rst_stall", W'(bus.stall_o), W'(0));
    chk("rst_busy", W'(bus.busy_o), W'(0));
    chk("rst_result", bus.result_o, '0);
    chk("rst_done", W'(bus.done_o), W'(0));
    // reset must win over an issue presented in the same cycle
    @(posedge clk); #1;
    rst = 1'b1; bus.valid_i = 1'b1; bus.ALUCtrl_i = ALU_MUL; bus.data1_i = 3; bus.data2_i = 3;
    @(posedge clk); #1;
    rst = 1'b0; bus.valid_i = 1'b0;
    @(negedge clk);
    chk("rst_override_busy", W'(bus.busy_o), W'(0));
    chk("rst_override_stall", W'(bus.stall_o), W'(0));
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1 with result 0x%0h, expected no pulse (cycle %0d)",
                   bus.result_o, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("mul_result", bus.result_o, e.res);
          chk("done_cycle", W'(cyc), W'(e.cyc));
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b1;
    exp_hold = '0;
    bus.valid_i = 1'b0; bus.ALUCtrl_i = ALU_ADD; bus.data1_i = '0; bus.data2_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_result", bus.result_o, '0);
    chk("reset_done", W'(bus.done_o), W'(0));
    chk("reset_stall", W'(bus.stall_o), W'(0));
    chk("reset_busy", W'(bus.busy_o), W'(0));

    do_mul(32'd7, 32'd6);
    bypass_cycle(1'b0, ALU_ADD);
    do_mul(32'hFFFF_FFFF, 32'd2);
    bypass_cycle(1'b0, ALU_ADD);
    do_mul(32'hFFFF_FFFD, 32'd5);
    repeat (5) bypass_cycle(1'b1, ALU_ADD);

    reset_mid_op();
    repeat (40) bypass_cycle(1'b0, ALU_MUL);

    do_mul(32'd1234, 32'd3);
    bypass_cycle(1'b0, ALU_ADD);
    do_mul(32'd5, 32'd0);
    bypass_cycle(1'b0, ALU_ADD);

    // MUL left on the inputs through DONE, then a fresh MUL right at the next IDLE cycle
    do_mul(32'd11, 32'd13);
    do_mul(32'd2, 32'd9);
    bypass_cycle(1'b0, ALU_ADD);

    for (int unsigned i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = '0;
      do_mul(a, b);
      if ($urandom_range(0, 1) == 1) rand_bypass($urandom_range(1, 4));
    end
    rand_bypass(40);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle multiply sequencer for the EX stage. When the ALU control encoding selects MUL, it owns the multiply operation and stalls the pipeline. It runs an iterative shift-add multiply and returns the low WIDTH bits of the product. It then releases the stall for exactly one cycle so the pipeline can capture the result. All other ALU operations bypass it untouched.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count without early termination

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  EX-stage instruction valid
- ALUCtrl_i  in  3  ALU control encoding; MUL = 3'b011
- data1_i  in  WIDTH  multiplicand (rs)
- data2_i  in  WIDTH  multiplier (rt)
- result_o  out  WIDTH  product low half; held until next issue
- done_o  out  1  one-cycle pulse, result_o valid
- stall_o  out  1  freeze PC, IF/ID, ID/EX while high
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- Issue condition: state IDLE and valid_i and ALUCtrl_i == 3'b011. On issue:
  - latch mcand = data1_i, mplier = data2_i
  - acc = 0, count = 0
  - next state RUN
- stall_o = issue condition (combinational, IDLE only) OR state == RUN.
- RUN step, once per cycle:
  - if mplier[0], then acc += mcand (mod 2^WIDTH)
  - mcand <<= 1, mplier >>= 1 (logical), count += 1
  - terminate when count reaches WIDTH, or early-term condition (see Configuration); next state DONE.
- DONE:
  - result_o = acc, done_o = 1, stall_o = 0
  - valid_i/ALUCtrl_i ignored (the same instruction is still present this cycle; it must not re-issue)
  - next state IDLE unconditionally.
- Arithmetic:
  - Unsigned shift-add over WIDTH bits; carries beyond WIDTH discarded.
  - The low half is identical for signed two's-complement operands, so no sign handling.
- Non-MUL encodings, or valid_i low: no state change, stall_o = 0.
- Reset values: state IDLE, acc/mcand/mplier/count 0, result_o 0, done_o 0, stall_o 0, busy_o 0.
- Reset mid-operation (RUN or DONE):
  - next cycle IDLE with all reset values
  - the partial product is discarded, no done_o pulse
  - rst_i overrides the issue condition in the same cycle.

## Timing
- Issue at cycle T (stall_o high from T).
- Without early termination:
  - RUN for cycles T+1..T+WIDTH
  - DONE at T+WIDTH+1: stall_o low, done_o high
  - stall_o is high for exactly WIDTH+1 cycles.
- Earliest next issue is at T+WIDTH+2 (IDLE).
- Back-to-back MULs therefore cost WIDTH+2 cycles each.
- result_o is registered and updates only on DONE entry.
- busy_o is registered: high T+1 through DONE inclusive.

## Configuration
- MUL_EARLY_TERM_EN defined:
  - in RUN, also terminate when the post-shift mplier == 0
  - latency is (index of highest set multiplier bit + 1) RUN cycles, minimum 1
  - multiplier 0 reaches DONE at T+2.
- Undefined: always exactly WIDTH RUN cycles; latency is data-independent.

## Structure
- Shared package holds:
  - ALU control encodings: AND 3'b000, OR 3'b001, ADD 3'b010, SUB 3'b110, MUL 3'b011, SLT 3'b111
  - the state enum.
- The ALU control decoder and this block both import the package.
- One natural sub-module, mul_shift_add_dp:
  - contains the mcand/mplier/acc registers and adder, plus load/step controls
  - the FSM, count and handshake stay in mul_seq_ctrl.

## Test plan
- Basic multiply, macro off: 7 * 6 issued at T.
  - stall_o high T..T+32
  - done_o pulse only at T+33
  - result_o = 42
- Wrap-around, macro off:
  - 0xFFFFFFFF * 2 -> 0xFFFFFFFE
  - 0xFFFFFFFD (-3) * 5 -> 0xFFFFFFF1 (-15)
- Bypass: valid_i = 1 with ALUCtrl_i = 3'b010 (ADD) held 5 cycles.
  - stall_o, busy_o, done_o stay 0
  - result_o unchanged
- Reset mid-op: issue 100 * 100, assert rst_i at T+10.
  - at T+11: state IDLE, stall_o = 0, busy_o = 0, result_o = 0
  - no done_o pulse ever
- Early termination, macro on:
  - 1234 * 3 -> DONE at T+3, result_o = 3702
  - 5 * 0 -> DONE at T+2, result_o = 0
- Back-to-back: MUL held on inputs through DONE.
  - no re-issue in DONE
  - fresh MUL 2 * 9 issued at T+34 -> result_o = 18 at T+34+33
